// File: rtl/uart_rfifo_gen.sv
// Purpose : UART receive FIFO storing {flags, data} entries with show-ahead head,
//           sticky overrun/read-empty flags, error-entry count, trigger level and
//           character-timeout detector.
// Latency : data_out is combinational from the head entry (zero read latency);
//           count/flags/err_count update on the strobe edge.
// Backpr. : pushes while full are dropped (overrun) unless a pop retires an entry
//           in the same cycle; pops while empty are ignored (read_empty).
// Ports   : clk, wb_rst_i (async active-high), fifo_reset/reset_status (sync),
//           push/data_in, pop/data_out, count/full/empty/overrun/read_empty,
//           err_count/error_bit, trig_lvl/trig_hit, tout_limit/char_timeout.
module uart_rfifo_gen #(
   parameter int DATA_W = 8,
   parameter int FLAG_W = 3,
   parameter int DEPTH  = 16,
   parameter int PTR_W  = 4,
   parameter int CNT_W  = 5,
   parameter int TOUT_W = 16
) (
   input  logic                     clk,
   input  logic                     wb_rst_i,
   input  logic                     fifo_reset,
   input  logic                     reset_status,
   input  logic                     push,
   input  logic [DATA_W+FLAG_W-1:0] data_in,
   input  logic                     pop,
   output logic [DATA_W+FLAG_W-1:0] data_out,
   output logic [CNT_W-1:0]         count,
   output logic                     full,
   output logic                     empty,
   output logic                     overrun,
   output logic                     read_empty,
   output logic [CNT_W-1:0]         err_count,
   output logic                     error_bit,
   input  logic [CNT_W-1:0]         trig_lvl,
   output logic                     trig_hit,
   input  logic [TOUT_W-1:0]        tout_limit,
   output logic                     char_timeout
);

   localparam int ENT_W = DATA_W + FLAG_W;

   logic [ENT_W-1:0]  mem_q [DEPTH];

   logic [PTR_W-1:0]  top_q, top_d;
   logic [PTR_W-1:0]  bottom_q, bottom_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [CNT_W-1:0]  err_count_q, err_count_d;
   logic              overrun_q, overrun_d;
   logic              read_empty_q, read_empty_d;
   logic [TOUT_W-1:0] idle_q, idle_d;
   logic              char_timeout_q, char_timeout_d;

   logic              full_w, empty_w;
   logic              push_eff, pop_eff, wr_en;
   logic              push_err, pop_err;
   logic [ENT_W-1:0]  head;
   logic [CNT_W-1:0]  trig_eff;

   always_comb begin
      full_w   = (count_q == CNT_W'(DEPTH));
      empty_w  = (count_q == '0);
      // A pop in the same cycle frees the slot, so push at full is still legal.
      push_eff = push & (~full_w | pop);
      pop_eff  = pop & ~empty_w;
      wr_en    = push_eff & ~fifo_reset;
      head     = mem_q[bottom_q];
      push_err = push_eff & (|data_in[ENT_W-1:DATA_W]);
      pop_err  = pop_eff & (|head[ENT_W-1:DATA_W]);
      trig_eff = (trig_lvl == '0) ? CNT_W'(1) : trig_lvl;
   end

   always_comb begin
      top_d          = top_q;
      bottom_d       = bottom_q;
      count_d        = count_q;
      err_count_d    = err_count_q;
      overrun_d      = overrun_q;
      read_empty_d   = read_empty_q;
      idle_d         = idle_q;
      char_timeout_d = char_timeout_q;

      if (fifo_reset) begin
         top_d          = '0;
         bottom_d       = '0;
         count_d        = '0;
         err_count_d    = '0;
         overrun_d      = 1'b0;
         read_empty_d   = 1'b0;
         idle_d         = '0;
         char_timeout_d = 1'b0;
      end else begin
         if (push_eff) top_d = top_q + PTR_W'(1);
         if (pop_eff)  bottom_d = bottom_q + PTR_W'(1);

         case ({push_eff, pop_eff})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase

         case ({push_err, pop_err})
            2'b10:   err_count_d = err_count_q + CNT_W'(1);
            2'b01:   err_count_d = err_count_q - CNT_W'(1);
            default: err_count_d = err_count_q;
         endcase

         if (push & full_w & ~pop) overrun_d = 1'b1;
         if (pop & empty_w)        read_empty_d = 1'b1;
         // Clear wins over a coincident set.
         if (reset_status) begin
            overrun_d    = 1'b0;
            read_empty_d = 1'b0;
         end

         if (push | pop | empty_w) begin
            idle_d = '0;
         end else if (idle_q != '1) begin
            idle_d = idle_q + TOUT_W'(1);
         end

         if (push | pop | (count_d == '0)) begin
            char_timeout_d = 1'b0;
         end else if (!empty_w && (tout_limit != '0) && (idle_d == tout_limit)) begin
            char_timeout_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         top_q          <= '0;
         bottom_q       <= '0;
         count_q        <= '0;
         err_count_q    <= '0;
         overrun_q      <= 1'b0;
         read_empty_q   <= 1'b0;
         idle_q         <= '0;
         char_timeout_q <= 1'b0;
      end else begin
         top_q          <= top_d;
         bottom_q       <= bottom_d;
         count_q        <= count_d;
         err_count_q    <= err_count_d;
         overrun_q      <= overrun_d;
         read_empty_q   <= read_empty_d;
         idle_q         <= idle_d;
         char_timeout_q <= char_timeout_d;
      end
   end

   // Storage needs no reset: data_out is forced to 0 whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[top_q] <= data_in;
   end

   assign data_out     = empty_w ? '0 : head;
   assign count        = count_q;
   assign full         = full_w;
   assign empty        = empty_w;
   assign overrun      = overrun_q;
   assign read_empty   = read_empty_q;
   assign err_count    = err_count_q;
   assign error_bit    = (err_count_q != '0);
   assign trig_hit     = (count_q >= trig_eff);
   assign char_timeout = char_timeout_q;

endmodule

// File: tb/tb_uart_rfifo_gen.sv
module tb_uart_rfifo_gen;

   localparam int DW = 8, FW = 3, EW = 11, DEPTH = 16;

   logic          clk = 1'b0;
   logic          wb_rst_i, fifo_reset, reset_status, push, pop;
   logic [EW-1:0] data_in, data_out;
   logic [4:0]    count, err_count, trig_lvl;
   logic          full, empty, overrun, read_empty, error_bit, trig_hit, char_timeout;
   logic [15:0]   tout_limit;

   int total = 0;
   int bad   = 0;
   logic [EW-1:0] sb[$];
   logic [EW-1:0] exp_v;

   always #5 clk = ~clk;

   uart_rfifo_gen #(.DATA_W(DW), .FLAG_W(FW), .DEPTH(DEPTH), .PTR_W(4), .CNT_W(5), .TOUT_W(16)) dut (
      .clk(clk), .wb_rst_i(wb_rst_i), .fifo_reset(fifo_reset), .reset_status(reset_status),
      .push(push), .data_in(data_in), .pop(pop), .data_out(data_out),
      .count(count), .full(full), .empty(empty), .overrun(overrun), .read_empty(read_empty),
      .err_count(err_count), .error_bit(error_bit), .trig_lvl(trig_lvl), .trig_hit(trig_hit),
      .tout_limit(tout_limit), .char_timeout(char_timeout)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   // Called at a falling edge; applies one cycle of strobes and returns at the next
   // falling edge. Models the accepted pushes into the scoreboard queue.
   task automatic step(input logic p, input logic q, input logic [EW-1:0] d,
                       input logic fr, input logic rs);
      int pre;
      pre = sb.size();
      push = p; pop = q; data_in = d; fifo_reset = fr; reset_status = rs;
      @(posedge clk);
      if (fr) sb.delete();
      else if (p && (pre < DEPTH || q)) sb.push_back(d);
      @(negedge clk);
      push = 0; pop = 0; data_in = '0; fifo_reset = 0; reset_status = 0;
   endtask

   task automatic test_reset();
      wb_rst_i = 1; fifo_reset = 0; reset_status = 0; push = 0; pop = 0;
      data_in = '0; trig_lvl = '0; tout_limit = '0;
      repeat (2) @(negedge clk);
      total++; if (count !== 5'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", count); end
      total++; if (empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL rst_empty_full got=%b%b want=10", empty, full); end
      total++; if ({overrun, read_empty, error_bit, char_timeout, trig_hit} !== 5'b0) begin bad++;
         $display("FAIL rst_flags got=%b want=00000", {overrun, read_empty, error_bit, char_timeout, trig_hit}); end
      total++; if (data_out !== '0 || err_count !== '0) begin bad++; $display("FAIL rst_data got=%h/%0d want=0/0", data_out, err_count); end
      wb_rst_i = 0;
      @(negedge clk);
      for (int i = 0; i < 5; i++) step(1, 0, EW'(8'hA0 + i), 0, 0);
      total++; if (count !== 5'd5) begin bad++; $display("FAIL pre_rst_count got=%0d want=5", count); end
      #2 wb_rst_i = 1;
      #1;
      total++; if (count !== 5'd0 || empty !== 1'b1 || data_out !== '0) begin bad++;
         $display("FAIL async_rst got count=%0d empty=%b data=%h want 0/1/0", count, empty, data_out); end
      sb.delete();
      @(negedge clk);
      wb_rst_i = 0;
   endtask

   task automatic test_fill_overflow();
      for (int i = 0; i < 3; i++) step(1, 0, EW'(8'h01 + i), 0, 0);
      for (int i = 0; i < 3; i++) begin
         exp_v = sb.pop_front();
         total++; if (data_out !== exp_v) begin bad++; $display("FAIL pre_pop got=%h want=%h", data_out, exp_v); end
         step(0, 1, '0, 0, 0);
      end
      for (int i = 0; i < 17; i++) step(1, 0, EW'(8'h30 + i), 0, 0);
      total++; if (count !== 5'd16 || full !== 1'b1) begin bad++; $display("FAIL fill_count got=%0d full=%b want=16/1", count, full); end
      total++; if (overrun !== 1'b1) begin bad++; $display("FAIL fill_overrun got=%b want=1", overrun); end
      total++; if (sb.size() != 16) begin bad++; $display("FAIL sb_size got=%0d want=16", sb.size()); end
      for (int i = 0; i < 16; i++) begin
         exp_v = sb.pop_front();
         total++; if (data_out !== exp_v) begin bad++; $display("FAIL fill_pop%0d got=%h want=%h", i, data_out, exp_v); end
         step(0, 1, '0, 0, 0);
      end
      total++; if (empty !== 1'b1 || data_out !== '0) begin bad++; $display("FAIL drain got empty=%b data=%h want 1/0", empty, data_out); end
      total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_sticky got=%b want=1", overrun); end
      step(0, 0, '0, 0, 1);
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_status got=%b want=0", overrun); end
   endtask

   task automatic test_simultaneous();
      for (int i = 0; i < 16; i++) step(1, 0, EW'(8'h60 + i), 0, 0);
      exp_v = sb.pop_front();
      total++; if (data_out !== exp_v) begin bad++; $display("FAIL full_pp_head got=%h want=%h", data_out, exp_v); end
      step(1, 1, EW'(8'h99), 0, 0);
      total++; if (count !== 5'd16 || overrun !== 1'b0) begin bad++;
         $display("FAIL full_pp got count=%0d overrun=%b want 16/0", count, overrun); end
      for (int i = 0; i < 16; i++) begin
         exp_v = sb.pop_front();
         total++; if (data_out !== exp_v) begin bad++; $display("FAIL pp_drain%0d got=%h want=%h", i, data_out, exp_v); end
         step(0, 1, '0, 0, 0);
      end
      step(1, 1, EW'(8'h5A), 0, 0);
      total++; if (count !== 5'd1 || read_empty !== 1'b1) begin bad++;
         $display("FAIL empty_pp got count=%0d read_empty=%b want 1/1", count, read_empty); end
      exp_v = sb.pop_front();
      total++; if (data_out !== exp_v || exp_v !== EW'(8'h5A)) begin bad++; $display("FAIL empty_pp_data got=%h want=05a", data_out); end
      step(0, 1, '0, 0, 1);
      total++; if (read_empty !== 1'b0 || empty !== 1'b1) begin bad++;
         $display("FAIL pp_cleanup got read_empty=%b empty=%b want 0/1", read_empty, empty); end
   endtask

   task automatic test_errors();
      logic [EW-1:0] vals [4];
      logic [4:0]    exp_err [4];
      vals = '{11'h041, 11'h142, 11'h443, 11'h044};
      exp_err = '{5'd2, 5'd1, 5'd0, 5'd0};
      foreach (vals[i]) step(1, 0, vals[i], 0, 0);
      total++; if (err_count !== 5'd2 || error_bit !== 1'b1) begin bad++;
         $display("FAIL err_after_push got=%0d/%b want=2/1", err_count, error_bit); end
      for (int i = 0; i < 4; i++) begin
         exp_v = sb.pop_front();
         total++; if (data_out !== exp_v) begin bad++; $display("FAIL err_pop%0d got=%h want=%h", i, data_out, exp_v); end
         step(0, 1, '0, 0, 0);
         total++; if (err_count !== exp_err[i] || error_bit !== (exp_err[i] != 0)) begin bad++;
            $display("FAIL err_count_pop%0d got=%0d/%b want=%0d", i, err_count, error_bit, exp_err[i]); end
      end
   endtask

   task automatic test_trig_timeout();
      trig_lvl = 5'd4; tout_limit = 16'd10;
      for (int i = 0; i < 3; i++) step(1, 0, EW'(8'hC0 + i), 0, 0);
      total++; if (trig_hit !== 1'b0) begin bad++; $display("FAIL trig3 got=%b want=0", trig_hit); end
      step(1, 0, EW'(8'hC3), 0, 0);
      total++; if (trig_hit !== 1'b1) begin bad++; $display("FAIL trig4 got=%b want=1", trig_hit); end
      repeat (9) @(negedge clk);
      total++; if (char_timeout !== 1'b0) begin bad++; $display("FAIL tout_early got=%b want=0", char_timeout); end
      @(negedge clk);
      total++; if (char_timeout !== 1'b1) begin bad++; $display("FAIL tout_edge got=%b want=1", char_timeout); end
      exp_v = sb.pop_front();
      total++; if (data_out !== exp_v) begin bad++; $display("FAIL tout_pop got=%h want=%h", data_out, exp_v); end
      step(0, 1, '0, 0, 0);
      total++; if (char_timeout !== 1'b0 || trig_hit !== 1'b0) begin bad++;
         $display("FAIL tout_clear got tout=%b trig=%b want 0/0", char_timeout, trig_hit); end
      trig_lvl = 5'd0;
      #1;
      total++; if (trig_hit !== 1'b1) begin bad++; $display("FAIL trig_zero got=%b want=1", trig_hit); end
      tout_limit = 16'd0;
      repeat (40) @(negedge clk);
      total++; if (char_timeout !== 1'b0) begin bad++; $display("FAIL tout_disabled got=%b want=0", char_timeout); end
      while (sb.size() > 0) begin
         exp_v = sb.pop_front();
         total++; if (data_out !== exp_v) begin bad++; $display("FAIL tout_drain got=%h want=%h", data_out, exp_v); end
         step(0, 1, '0, 0, 0);
      end
   endtask

   task automatic test_flush();
      step(0, 1, '0, 0, 1);
      total++; if (read_empty !== 1'b0) begin bad++; $display("FAIL set_vs_clear got=%b want=0", read_empty); end
      step(0, 1, '0, 0, 0);
      total++; if (read_empty !== 1'b1) begin bad++; $display("FAIL read_empty_set got=%b want=1", read_empty); end
      for (int i = 0; i < 7; i++) step(1, 0, EW'(11'h100 * (i % 2) + 11'h20 + i), 0, 0);
      total++; if (count !== 5'd7 || err_count !== 5'd3) begin bad++;
         $display("FAIL pre_flush got count=%0d err=%0d want 7/3", count, err_count); end
      step(1, 0, EW'(11'h777), 1, 0);
      total++; if (count !== 5'd0 || err_count !== 5'd0 || empty !== 1'b1) begin bad++;
         $display("FAIL flush_count got count=%0d err=%0d empty=%b want 0/0/1", count, err_count, empty); end
      total++; if ({overrun, read_empty, char_timeout, error_bit} !== 4'b0 || data_out !== '0) begin bad++;
         $display("FAIL flush_flags got=%b data=%h want 0000/0", {overrun, read_empty, char_timeout, error_bit}, data_out); end
      step(1, 0, EW'(8'h3C), 0, 0);
      total++; if (count !== 5'd1 || data_out !== EW'(8'h3C)) begin bad++;
         $display("FAIL post_flush got count=%0d data=%h want 1/03c", count, data_out); end
   endtask

   initial begin
      test_reset();
      test_fill_overflow();
      test_simultaneous();
      test_errors();
      test_trig_timeout();
      test_flush();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_rfifo_gen.md
# uart_rfifo_gen

Parametrised UART receive FIFO, the next generation of the 16550-style receiver buffer. It stores received characters together with their per-character error flags, and presents the head entry show-ahead to the register interface. It adds several status outputs:
- full, empty, overrun and read-empty flags;
- a live count of erroneous entries;
- a programmable trigger level;
- a programmable character-timeout detector.

It sits between the receive shift/deserialiser logic (push side) and the RBR/LSR/IIR register logic (pop side).

## Interface
- DATA_W, 8, character data bits per entry
- FLAG_W, 3, error flag bits per entry: bit0 parity, bit1 framing, bit2 break (any nonzero = erroneous)
- DEPTH, 16, entries; power of two, ≥2
- PTR_W, 4, log2(DEPTH)
- CNT_W, 5, PTR_W+1
- TOUT_W, 16, width of timeout limit/counter
- clk  in  1  single clock; all state changes on its rising edge
- wb_rst_i  in  1  asynchronous, active-high reset
- fifo_reset  in  1  synchronous flush: pointers, count, err_count, idle counter to 0; clears overrun/read_empty/char_timeout
- reset_status  in  1  synchronous clear of sticky overrun and read_empty only
- push  in  1  write strobe
- data_in  in  DATA_W+FLAG_W  {flags, data}; flags in MSBs
- pop  in  1  read strobe; retires head entry
- data_out  out  DATA_W+FLAG_W  head entry (show-ahead); 0 when empty
- count  out  CNT_W  occupancy 0..DEPTH
- full  out  1  count==DEPTH
- empty  out  1  count==0
- overrun  out  1  sticky: push dropped because full
- read_empty  out  1  sticky: pop attempted while empty
- err_count  out  CNT_W  stored entries with nonzero flags
- error_bit  out  1  err_count!=0 (LSR bit 7)
- trig_lvl  in  CNT_W  trigger threshold; 0 treated as 1
- trig_hit  out  1  count ≥ max(trig_lvl,1)
- tout_limit  in  TOUT_W  idle cycles before timeout; 0 disables
- char_timeout  out  1  registered timeout indication

## Operation
- On wb_rst_i (async): all registers are 0.
  - Outputs: count=0, empty=1, full=0, overrun=0, read_empty=0, err_count=0, error_bit=0, char_timeout=0, data_out=0, trig_hit=0.
  - Storage contents are don't-care.
- fifo_reset has priority over push/pop in the same cycle. Push and pop in that cycle are discarded.
- The effective push is push & (~full | pop). The effective pop is pop & ~empty.
- push only, not full: the entry is written at top, top+1, count+1.
- push only, full: the entry is dropped, overrun←1, and pointers and count are unchanged.
- pop only, not empty: bottom+1, count−1.
- pop only, empty: no pointer change, read_empty←1.
- push & pop, 0<count≤DEPTH: both execute, count unchanged. At full this is legal and does not set overrun.
- push & pop, empty: the push executes and the pop is ignored. read_empty←1 and count→1.
- Pointers wrap modulo DEPTH.
- err_count is +1 on an effective push with nonzero flags, and −1 on an effective pop whose head flags are nonzero. When both occur, the net change applies. err_count never exceeds count.
- The sticky flags hold until reset_status, fifo_reset or wb_rst_i. A set condition and reset_status in the same cycle resolves to clear.
- Idle counter (TOUT_W bits, saturating):
  - cleared on any push, pop, fifo_reset, or when count==0;
  - otherwise increments.
  - char_timeout←1 on the edge where the counter reaches tout_limit with count>0 and tout_limit≠0.
  - char_timeout←0 on any push/pop/fifo_reset, or when count becomes 0.

## Timing
- count, flags, err_count and data_out update on the same edge as the strobe. They are visible the cycle after the strobe is sampled.
- data_out is combinational from storage at bottom. Zero read latency: the pop-cycle data_out is the entry being retired.
- trig_hit, full, empty and error_bit are combinational from registered state. trig_lvl changes take effect immediately.
- char_timeout asserts exactly tout_limit idle edges after the last push/pop, provided count>0 throughout.

## Test plan
- Reset mid-operation: push 5 entries, assert wb_rst_i asynchronously between edges. Outputs go to their reset values immediately, without waiting for a clock edge: count=0, empty=1, data_out=0.
- Fill/overflow, DEPTH=16: push 17 distinct values.
  - count=16, full=1, overrun=1, and the 17th value is absent.
  - 16 pops return the values in order with wrap-around.
  - reset_status clears overrun.
- Simultaneous strobes:
  - push&pop at full: count stays 16, overrun stays 0.
  - push&pop at empty: count=1, read_empty=1, and data_out equals the pushed value.
- Error tracking: push 0x041, 0x142 (parity), 0x443 (break), 0x044.
  - err_count=2, error_bit=1.
  - After 2 pops err_count=1; after 3 pops err_count=0.
- Trigger and timeout: trig_lvl=4, tout_limit=10.
  - Push 3 → trig_hit=0; push 1 more → trig_hit=1.
  - Idle for 10 edges → char_timeout=1. A single pop clears it.
  - With tout_limit=0, char_timeout never asserts.
- Flush priority: fifo_reset together with push at count=7.
  - The next cycle shows count=0, err_count=0, and all sticky flags at 0.
